seg_display_sched: RTL

Time-multiplexing scheduler that shares the board's two-digit hex seven-segment display between several independent requesters (BIOS POST-code port, debug probes, error reporters). Each requester offers an 8-bit value over a valid/ready handshake. The block grants the display round-robin, holds each granted value for a minimum dwell time so a human can read it, and drives the 8-bit value input of the display decoder.

---
 rtl/seg_display_sched_pkg.sv | 21 ++
 rtl/seg_display_sched_rr_arbiter.sv | 58 +++++
 rtl/seg_display_sched.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/seg_display_sched_pkg.sv
// Shared definitions for the seven-segment display scheduler:
// scheduler state encodings and the source-index width helper.
package seg_display_sched_pkg;

   // Scheduler states; ST_BLANK is only reachable when SEG_SCHED_BLANK_EN is defined.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHOW  = 2'd1,
      ST_BLANK = 2'd2
   } sched_state_e;

   // Width of a source index; never less than one bit.
   function automatic int src_idx_w(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/seg_display_sched_rr_arbiter.sv
// Combinational round-robin arbiter. Searches from ptr_i upwards (modulo N),
// skipping the source flagged in low_i; that source wins only when nobody
// else requests.
module rr_arbiter
   import seg_display_sched_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = src_idx_w(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   input  logic [N-1:0]  low_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   logic [IW:0]   sum_s;
   logic [IW-1:0] cand_s;
   logic          found_s;

   // Priority search: normal sources in RR order, then the low-priority one.
   always_comb begin
      gnt_o   = {N{1'b0}};
      idx_o   = {IW{1'b0}};
      found_s = 1'b0;
      sum_s   = {(IW+1){1'b0}};
      cand_s  = {IW{1'b0}};
      for (int off = 0; off < N; off++) begin
         sum_s = {1'b0, ptr_i} + (IW+1)'(off);
         if (sum_s >= (IW+1)'(N)) begin
            cand_s = IW'(sum_s - (IW+1)'(N));
         end else begin
            cand_s = IW'(sum_s);
         end
         for (int i = 0; i < N; i++) begin
            if (!found_s && req_i[i] && !low_i[i] && (cand_s == IW'(i))) begin
               gnt_o[i] = 1'b1;
               idx_o    = IW'(i);
               found_s  = 1'b1;
            end else begin
               found_s  = found_s;
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found_s && req_i[i] && low_i[i]) begin
            gnt_o[i] = 1'b1;
            idx_o    = IW'(i);
            found_s  = 1'b1;
         end else begin
            found_s  = found_s;
         end
      end
      any_o = found_s;
   end

endmodule

// File: rtl/seg_display_sched.sv
// Round-robin time-multiplexing scheduler for a two-digit hex display.
// Each grant is held for HOLD_CYCLES; the owner may refresh its value
// in place. Optional macro SEG_SCHED_BLANK_EN inserts a dark gap of
// BLANK_CYCLES whenever the owner changes.
module seg_display_sched
   import seg_display_sched_pkg::*;
#(
   parameter int NUM_SRC      = 4,
   parameter int HOLD_CYCLES  = 25000000,
   parameter int BLANK_CYCLES = 250000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_SRC-1:0]            req_valid,
   input  logic [NUM_SRC*8-1:0]          req_value,
   output logic [NUM_SRC-1:0]            req_ready,
   output logic [7:0]                    value,
   output logic [src_idx_w(NUM_SRC)-1:0] owner,
   output logic                          busy,
   output logic                          blank
);

   localparam int            IW        = src_idx_w(NUM_SRC);
   localparam int            CW        = $clog2(HOLD_CYCLES + 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [IW-1:0] LAST_SRC  = IW'(NUM_SRC - 1);

   sched_state_e         state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        rr_q, rr_d;
   logic [IW-1:0]        owner_q, owner_d;
   logic [7:0]           value_q, value_d;
   logic                 busy_q;
   logic [NUM_SRC-1:0]   ready_s;
   logic [NUM_SRC-1:0]   low_s;
   logic [NUM_SRC-1:0]   gnt_s;
   logic [IW-1:0]        idx_s;
   logic                 any_s;
   logic [IW-1:0]        next_rr_s;

`ifdef SEG_SCHED_BLANK_EN
   localparam int            BW         = $clog2(BLANK_CYCLES + 1);
   localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
   logic [BW-1:0]        bcnt_q, bcnt_d;
   logic                 blank_q;
`endif

   rr_arbiter #(
      .N  (NUM_SRC),
      .IW (IW)
   ) u_arb (
      .req_i (req_valid),
      .ptr_i (rr_q),
      .low_i (low_s),
      .gnt_o (gnt_s),
      .idx_o (idx_s),
      .any_o (any_s)
   );

   // While showing, the current owner is demoted to lowest priority at expiry.
   always_comb begin
      low_s = {NUM_SRC{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
         if ((state_q == ST_SHOW) && (owner_q == IW'(i))) begin
            low_s[i] = 1'b1;
         end else begin
            low_s[i] = 1'b0;
         end
      end
   end

   // Pointer value following a grant to the arbiter winner (wraps at NUM_SRC).
   always_comb begin
      if (idx_s == LAST_SRC) begin
         next_rr_s = {IW{1'b0}};
      end else begin
         next_rr_s = idx_s + IW'(1);
      end
   end

   // Next-state, handshake and display-content logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rr_d    = rr_q;
      owner_d = owner_q;
      value_d = value_q;
      ready_s = {NUM_SRC{1'b0}};
`ifdef SEG_SCHED_BLANK_EN
      bcnt_d  = bcnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (any_s) begin
               ready_s = gnt_s;
               value_d = req_value[{idx_s, 3'b000} +: 8];
               owner_d = idx_s;
               rr_d    = next_rr_s;
               cnt_d   = {CW{1'b0}};
               state_d = ST_SHOW;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHOW: begin
            if (cnt_q < HOLD_LAST) begin
               // Mid-dwell: only the owner may refresh; count keeps running.
               cnt_d = cnt_q + CW'(1);
               if (req_valid[owner_q]) begin
                  ready_s[owner_q] = 1'b1;
                  value_d          = req_value[{owner_q, 3'b000} +: 8];
               end else begin
                  value_d          = value_q;
               end
            end else if (!any_s) begin
               cnt_d   = {CW{1'b0}};
               state_d = ST_IDLE;
`ifdef SEG_SCHED_BLANK_EN
            end else if (idx_s != owner_q) begin
               cnt_d   = {CW{1'b0}};
               bcnt_d  = {BW{1'b0}};
               state_d = ST_BLANK;
`endif
            end else begin
               ready_s = gnt_s;
               value_d = req_value[{idx_s, 3'b000} +: 8];
               owner_d = idx_s;
               rr_d    = next_rr_s;
               cnt_d   = {CW{1'b0}};
               state_d = ST_SHOW;
            end
         end
`ifdef SEG_SCHED_BLANK_EN
         ST_BLANK: begin
            if (bcnt_q < BLANK_LAST) begin
               bcnt_d = bcnt_q + BW'(1);
            end else if (any_s) begin
               ready_s = gnt_s;
               value_d = req_value[{idx_s, 3'b000} +: 8];
               owner_d = idx_s;
               rr_d    = next_rr_s;
               cnt_d   = {CW{1'b0}};
               state_d = ST_SHOW;
            end else begin
               state_d = ST_IDLE;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset discards any in-flight handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= {CW{1'b0}};
         rr_q    <= {IW{1'b0}};
         owner_q <= {IW{1'b0}};
         value_q <= 8'h00;
         busy_q  <= 1'b0;
`ifdef SEG_SCHED_BLANK_EN
         bcnt_q  <= {BW{1'b0}};
         blank_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rr_q    <= rr_d;
         owner_q <= owner_d;
         value_q <= value_d;
         busy_q  <= (state_d != ST_IDLE);
`ifdef SEG_SCHED_BLANK_EN
         bcnt_q  <= bcnt_d;
         blank_q <= (state_d == ST_BLANK);
`endif
      end
   end

   assign req_ready = ready_s & {NUM_SRC{~rst}};
   assign value     = value_q;
   assign owner     = owner_q;
   assign busy      = busy_q;
`ifdef SEG_SCHED_BLANK_EN
   assign blank     = blank_q;
`else
   assign blank     = 1'b0;
`endif

endmodule
